// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, one bit per
// clock, repeated reps times with an optional idle gap between repetitions.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNTW-1:0]  len,
  input  logic [CNTW-1:0]  reps,
  input  logic [CNTW-1:0]  gap,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  rep_left
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IW-1:0]    lenm1_q, lenm1_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNTW-1:0]  gap_q, gap_d;
  logic [CNTW-1:0]  gcnt_q, gcnt_d;
  logic [CNTW-1:0]  rep_d;
  logic             x_d, x_valid_d, busy_d, done_d;
  logic [IW-1:0]    lenm1_in;
  logic [CNTW-1:0]  reps_in;

  // Effective length (as last-bit index) and repeat count from the raw inputs
  always_comb begin
    if (len == '0 || 32'(len) > WIDTH) lenm1_in = IW'(WIDTH - 1);
    else                               lenm1_in = IW'(len - CNTW'(1));
    reps_in = (reps == '0) ? CNTW'(1) : reps;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      lenm1_q  <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      rep_left <= '0;
      x        <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pat_q    <= pat_d;
      lenm1_q  <= lenm1_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      rep_left <= rep_d;
      x        <= x_d;
      x_valid  <= x_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    pat_d     = pat_q;
    lenm1_d   = lenm1_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    rep_d     = rep_left;
    x_d       = x;
    x_valid_d = x_valid;
    busy_d    = busy;
    done_d    = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
      rep_d     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
          if (start) begin
            state_d   = SEND;
            pat_d     = pattern;
            lenm1_d   = lenm1_in;
            gap_d     = gap;
            idx_d     = lenm1_in;
            rep_d     = reps_in;
            x_d       = pattern[lenm1_in];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
        SEND: begin
          if (idx_q != '0) begin
            idx_d = idx_q - IW'(1);
            x_d   = pat_q[idx_q - IW'(1)];
          end else if (rep_left > CNTW'(1)) begin
            rep_d = rep_left - CNTW'(1);
            if (gap_q != '0) begin
              state_d   = GAP;
              gcnt_d    = gap_q - CNTW'(1);
              x_d       = 1'b0;
              x_valid_d = 1'b0;
            end else begin
              idx_d = lenm1_q;
              x_d   = pat_q[lenm1_q];
            end
          end else begin
            state_d   = IDLE;
            rep_d     = '0;
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end
        GAP: begin
          if (gcnt_q == '0) begin
            state_d   = SEND;
            idx_d     = lenm1_q;
            x_d       = pat_q[lenm1_q];
            x_valid_d = 1'b1;
          end else begin
            gcnt_d = gcnt_q - CNTW'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
          rep_d     = '0;
        end
      endcase
    end
  end

endmodule
